dmem_arbiter: RTL

Two-port arbiter and sequencer that shares the single-port data memory (`dmem`) between the instruction-fetch requester and the load/store requester of the multicycle core. Accepts one request at a time and drives the `dmem` port for exactly one access cycle. Returns the registered read word to the winning requester with a one-cycle valid pulse. Sits between the core control unit and `dmem`; `dmem` writes on the rising clk edge and reads combinationally from `a`.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the fetch and load/store requesters: IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module dmem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wd,
   input  logic [3:0]    d_be,
   input  logic [1:0]    d_op,
   input  logic [1:0]    d_op2,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   output logic [3:0]    mem_be,
   output logic [1:0]    mem_op,
   output logic [1:0]    mem_op2,
   input  logic [DW-1:0] mem_rd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [3:0]    be;
      logic [1:0]    op;
      logic [1:0]    op2;
   } cmd_t;

   state_t        state, state_nxt;
   cmd_t          cmd, cmd_nxt;
   logic          win_d, win_d_nxt;
   logic          pick_d_c;
   logic          f_gnt_nxt, d_gnt_nxt, f_rvalid_nxt, d_rvalid_nxt;
   logic [DW-1:0] rdata_nxt;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d, last_d_nxt;

   // On contention, grant the port that did not win last time.
   assign pick_d_c = d_req && (!f_req || !last_d);
`else
   assign pick_d_c = d_req;
`endif

   // Next state, command capture and registered handshake outputs
   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd;
      win_d_nxt    = win_d;
      f_gnt_nxt    = 1'b0;
      d_gnt_nxt    = 1'b0;
      f_rvalid_nxt = 1'b0;
      d_rvalid_nxt = 1'b0;
      rdata_nxt    = rdata;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_nxt   = last_d;
`endif
      case (state)
         IDLE: begin
            if (f_req || d_req) begin
               state_nxt = ACCESS;
               win_d_nxt = pick_d_c;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_nxt = pick_d_c;
`endif
               if (pick_d_c) begin
                  cmd_nxt   = '{we: d_we, a: d_addr, wd: d_wd, be: d_be, op: d_op, op2: d_op2};
                  d_gnt_nxt = 1'b1;
               end else begin
                  cmd_nxt   = '{we: 1'b0, a: f_addr, wd: '0, be: 4'b1111, op: 2'b01, op2: 2'b00};
                  f_gnt_nxt = 1'b1;
               end
            end
         end
         ACCESS: begin
            state_nxt = RESP;
            if (!cmd.we) rdata_nxt = mem_rd;
         end
         RESP: begin
            state_nxt    = IDLE;
            d_rvalid_nxt = win_d;
            f_rvalid_nxt = !win_d;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cmd      <= '0;
         win_d    <= 1'b0;
         f_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         rdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d   <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cmd      <= cmd_nxt;
         win_d    <= win_d_nxt;
         f_gnt    <= f_gnt_nxt;
         d_gnt    <= d_gnt_nxt;
         f_rvalid <= f_rvalid_nxt;
         d_rvalid <= d_rvalid_nxt;
         rdata    <= rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
         last_d   <= last_d_nxt;
`endif
      end
   end

   // dmem port is live only in ACCESS; the write strobe is also gated by reset.
   assign mem_we  = (state == ACCESS) && cmd.we && reset_n;
   assign mem_a   = (state == ACCESS) ? cmd.a   : '0;
   assign mem_wd  = (state == ACCESS) ? cmd.wd  : '0;
   assign mem_be  = (state == ACCESS) ? cmd.be  : '0;
   assign mem_op  = (state == ACCESS) ? cmd.op  : '0;
   assign mem_op2 = (state == ACCESS) ? cmd.op2 : '0;

endmodule
